nonce_scheduler: RTL and testbench

//  Sequences a pool of SHA hashing cores for one mining job. Splits the 32-bit nonce space

---
 rtl/nonce_scheduler_pkg.sv | 21 ++
 rtl/nonce_scheduler_rr_arbiter.sv | 33 +++
 rtl/nonce_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_nonce_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_scheduler_pkg.sv
// Shared scheduler types: FSM state encoding and host response codes.
// Pure definitions; no latency or backpressure of its own.
package nonce_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLAIM = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam logic [1:0] RESP_NONE   = 2'b00;
  localparam logic [1:0] RESP_ACCEPT = 2'b01;
  localparam logic [1:0] RESP_REJECT = 2'b10;

  // Pointer width for n requesters; a lone requester still gets one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nonce_scheduler_rr_arbiter.sv
// Round-robin pick of the lowest requesting index at or above ptr, wrapping.
// Combinational, zero latency; no backpressure (grant is advisory).
module rr_arbiter
  import nonce_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Dispatches nonce chunks round-robin to SHA cores and arbitrates golden-nonce claims to the host.
// job_start->core_go 1 cycle, core_found->sol_claim 1 cycle; claims hold until host responds. Option: NONCE_SCHEDULER_STATS_EN.
module nonce_scheduler
  import nonce_sched_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int CHUNK_LG2 = 24
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    job_start,
  input  logic                    job_abort,
  input  logic [NUM_CORES-1:0]    core_idle,
  input  logic [NUM_CORES-1:0]    core_found,
  input  logic [NUM_CORES*32-1:0] core_nonce,
  output logic [NUM_CORES-1:0]    core_go,
  output logic [31:0]             core_base,
  output logic [NUM_CORES-1:0]    core_ack,
  output logic                    core_stop,
  output logic                    sol_claim,
  output logic [31:0]             sol_nonce,
  input  logic [1:0]              sol_response,
  output logic                    busy,
`ifdef NONCE_SCHEDULER_STATS_EN
  output logic [31:0]             chunks_done,
`endif
  output logic                    exhausted
);

  localparam int          PW         = ptr_width(NUM_CORES);
  localparam logic [32:0] CHUNK_STEP = 33'd1 << CHUNK_LG2;

  sched_state_t           state_q, state_d;
  logic [32:0]            next_base_q, next_base_d;
  logic [PW-1:0]          go_ptr_q, go_ptr_d;
  logic [PW-1:0]          found_ptr_q, found_ptr_d;
  logic [NUM_CORES-1:0]   pending_q, pending_d;

  logic [NUM_CORES-1:0]   go_d;
  logic [31:0]            base_d;
  logic [NUM_CORES-1:0]   ack_d;
  logic                   stop_d;
  logic                   claim_d;
  logic [31:0]            nonce_d;
  logic                   exh_d;

  logic [NUM_CORES-1:0]   disp_grant;
  logic [PW-1:0]          disp_idx;
  logic                   disp_vld;
  logic [NUM_CORES-1:0]   found_grant;
  logic [PW-1:0]          found_idx;
  logic                   found_vld;
  logic [31:0]            found_nonce;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) >= NUM_CORES - 1) return '0;
    return p + PW'(1);
  endfunction

  // A dispatched core stays ineligible until it has visibly dropped core_idle.
  rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_disp_arb (
    .req   (core_idle & ~pending_q),
    .ptr   (go_ptr_q),
    .grant (disp_grant),
    .idx   (disp_idx),
    .valid (disp_vld)
  );

  rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_found_arb (
    .req   (core_found),
    .ptr   (found_ptr_q),
    .grant (found_grant),
    .idx   (found_idx),
    .valid (found_vld)
  );

  always_comb begin
    found_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (found_grant[i]) found_nonce = core_nonce[32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    next_base_d = next_base_q;
    go_ptr_d    = go_ptr_q;
    found_ptr_d = found_ptr_q;
    pending_d   = pending_q & core_idle;
    go_d        = '0;
    base_d      = core_base;
    ack_d       = '0;
    stop_d      = 1'b0;
    claim_d     = sol_claim;
    nonce_d     = sol_nonce;
    exh_d       = exhausted;

    if (job_abort) begin
      if (state_q != IDLE) begin
        stop_d    = 1'b1;
        claim_d   = 1'b0;
        exh_d     = 1'b0;
        pending_d = '0;
        state_d   = IDLE;
      end
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (job_start) begin
            state_d     = RUN;
            exh_d       = 1'b0;
            next_base_d = '0;
            // First chunk goes out in the start cycle to meet the 1-cycle latency.
            if (disp_vld) begin
              go_d        = disp_grant;
              base_d      = '0;
              next_base_d = CHUNK_STEP;
              go_ptr_d    = ptr_inc(disp_idx);
              pending_d   = pending_d | disp_grant;
            end
          end
        end
        RUN: begin
          if (found_vld) begin
            ack_d       = found_grant;
            nonce_d     = found_nonce;
            claim_d     = 1'b1;
            found_ptr_d = ptr_inc(found_idx);
            state_d     = CLAIM;
          end else if (!next_base_q[32] && disp_vld) begin
            go_d        = disp_grant;
            base_d      = next_base_q[31:0];
            next_base_d = next_base_q + CHUNK_STEP;
            go_ptr_d    = ptr_inc(disp_idx);
            pending_d   = pending_d | disp_grant;
          end else if (next_base_q[32] && (&core_idle) && (pending_q == '0)) begin
            state_d = DONE;
            exh_d   = 1'b1;
          end
        end
        CLAIM: begin
          if (sol_response == RESP_ACCEPT) begin
            stop_d    = 1'b1;
            claim_d   = 1'b0;
            pending_d = '0;
            state_d   = DONE;
          end else if (sol_response != RESP_NONE) begin
            claim_d = 1'b0;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      next_base_q <= '0;
      go_ptr_q    <= '0;
      found_ptr_q <= '0;
      pending_q   <= '0;
      core_go     <= '0;
      core_base   <= '0;
      core_ack    <= '0;
      core_stop   <= 1'b0;
      sol_claim   <= 1'b0;
      sol_nonce   <= '0;
      exhausted   <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_base_q <= next_base_d;
      go_ptr_q    <= go_ptr_d;
      found_ptr_q <= found_ptr_d;
      pending_q   <= pending_d;
      core_go     <= go_d;
      core_base   <= base_d;
      core_ack    <= ack_d;
      core_stop   <= stop_d;
      sol_claim   <= claim_d;
      sol_nonce   <= nonce_d;
      exhausted   <= exh_d;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef NONCE_SCHEDULER_STATS_EN
  logic start_ok;
  assign start_ok = job_start && !job_abort && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chunks_done <= '0;
    end else if (start_ok) begin
      chunks_done <= '0;
    end else if ((|core_go) && (chunks_done != '1)) begin
      chunks_done <= chunks_done + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler: dispatch/claim scoreboards plus claim-response vector table.
module tb_nonce_scheduler;

  localparam int N  = 4;
  localparam int LG = 30;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          job_start, job_abort;
  logic [N-1:0]  core_idle, core_found;
  logic [N*32-1:0] core_nonce;
  logic [N-1:0]  core_go, core_ack;
  logic [31:0]   core_base, sol_nonce;
  logic          core_stop, sol_claim, busy, exhausted;
  logic [1:0]    sol_response;
`ifdef NONCE_SCHEDULER_STATS_EN
  logic [31:0]   chunks_done;
`endif

  always #5 clk = ~clk;

  nonce_scheduler #(.NUM_CORES(N), .CHUNK_LG2(LG)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .job_start    (job_start),
    .job_abort    (job_abort),
    .core_idle    (core_idle),
    .core_found   (core_found),
    .core_nonce   (core_nonce),
    .core_go      (core_go),
    .core_base    (core_base),
    .core_ack     (core_ack),
    .core_stop    (core_stop),
    .sol_claim    (sol_claim),
    .sol_nonce    (sol_nonce),
    .sol_response (sol_response),
    .busy         (busy),
`ifdef NONCE_SCHEDULER_STATS_EN
    .chunks_done  (chunks_done),
`endif
    .exhausted    (exhausted)
  );

`ifdef NONCE_SCHEDULER_STATS_EN
  logic          s_job_start, s_job_abort;
  logic [N-1:0]  s_core_idle, s_core_go, s_core_ack;
  logic [31:0]   s_core_base, s_sol_nonce, s_chunks_done;
  logic          s_core_stop, s_sol_claim, s_busy, s_exhausted;

  nonce_scheduler #(.NUM_CORES(N), .CHUNK_LG2(29)) dut_s (
    .clk          (clk),
    .n_rst        (n_rst),
    .job_start    (s_job_start),
    .job_abort    (s_job_abort),
    .core_idle    (s_core_idle),
    .core_found   (4'b0000),
    .core_nonce   (core_nonce),
    .core_go      (s_core_go),
    .core_base    (s_core_base),
    .core_ack     (s_core_ack),
    .core_stop    (s_core_stop),
    .sol_claim    (s_sol_claim),
    .sol_nonce    (s_sol_nonce),
    .sol_response (2'b00),
    .busy         (s_busy),
    .chunks_done  (s_chunks_done),
    .exhausted    (s_exhausted)
  );
`endif

  typedef struct { logic [N-1:0] go; logic [31:0] base; } go_exp_t;
  typedef struct { logic [N-1:0] ack; logic [31:0] nonce; } ack_exp_t;
  typedef struct { logic [N-1:0] found_set; logic [1:0] resp; int exp_core; logic exp_stop; } claim_vec_t;

  go_exp_t  go_q[$];
  ack_exp_t ack_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] nonce_of(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0001_1111;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock; then retire any dispatch/ack the DUT produced against the scoreboards.
  task automatic tick();
    @(posedge clk);
    #1;
    if (core_go != '0) begin
      if (go_q.size() == 0) check("unexpected_go", 64'(core_go), 64'd0);
      else begin
        go_exp_t e;
        e = go_q.pop_front();
        check("go_onehot", 64'(core_go), 64'(e.go));
        check("go_base", 64'(core_base), 64'(e.base));
      end
    end
    if (core_ack != '0) begin
      if (ack_q.size() == 0) check("unexpected_ack", 64'(core_ack), 64'd0);
      else begin
        ack_exp_t a;
        a = ack_q.pop_front();
        check("ack_onehot", 64'(core_ack), 64'(a.ack));
        check("claim_nonce", 64'(sol_nonce), 64'(a.nonce));
        check("claim_with_ack", 64'(sol_claim), 64'd1);
      end
    end
  endtask

  task automatic expect_claim(input int core);
    ack_q.push_back('{ack: N'(1) << core, nonce: nonce_of(core)});
  endtask

  task automatic wait_claim();
    int w;
    w = 0;
    do begin
      tick();
      w++;
    end while (!sol_claim && w < 6);
    check("claim_seen", 64'(sol_claim), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    claim_vec_t tbl [6];
    int w;
    logic stable;

    tbl[0] = '{found_set: 4'b1010, resp: 2'b10, exp_core: 1, exp_stop: 1'b0};
    tbl[1] = '{found_set: 4'b0000, resp: 2'b11, exp_core: 3, exp_stop: 1'b0};
    tbl[2] = '{found_set: 4'b0101, resp: 2'b10, exp_core: 0, exp_stop: 1'b0};
    tbl[3] = '{found_set: 4'b0000, resp: 2'b10, exp_core: 2, exp_stop: 1'b0};
    tbl[4] = '{found_set: 4'b0011, resp: 2'b10, exp_core: 0, exp_stop: 1'b0};
    tbl[5] = '{found_set: 4'b0000, resp: 2'b01, exp_core: 1, exp_stop: 1'b1};

    n_rst = 1'b0; job_start = 1'b0; job_abort = 1'b0;
    core_idle = '0; core_found = '0; sol_response = 2'b00;
    for (int i = 0; i < N; i++) core_nonce[32*i +: 32] = nonce_of(i);
`ifdef NONCE_SCHEDULER_STATS_EN
    s_job_start = 1'b0; s_job_abort = 1'b0; s_core_idle = '0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", {core_go, core_ack, core_stop, sol_claim, busy, exhausted}, 64'd0);
    check("reset_data", {core_base, sol_nonce}, 64'd0);
    n_rst = 1'b1;
    tick();

    // Reset asserted while a dispatch pulse is on the wire.
    core_idle = 4'hF;
    job_start = 1'b1;
    @(posedge clk);
    #1;
    job_start = 1'b0;
    check("start_latency_go", 64'(core_go), 64'b0001);
    n_rst = 1'b0;
    #1;
    check("midrun_reset_ctl", {core_go, core_ack, core_stop, sol_claim, busy, exhausted}, 64'd0);
    @(posedge clk);
    #1;
    check("midrun_reset_held", {core_go, core_base, busy}, 64'd0);
    n_rst = 1'b1;
    tick();
    check("post_reset_idle", {core_go, busy}, 64'd0);

    // Full sweep with four chunks, then exhaustion.
    for (int k = 0; k < 4; k++) go_q.push_back('{go: N'(1) << k, base: 32'(k) << LG});
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    repeat (5) tick();
    check("all_chunks_dispatched", 64'(go_q.size()), 64'd0);
    check("not_exhausted_while_busy", {busy, exhausted}, 64'b10);
    core_idle = 4'h0;
    tick();
    tick();
    core_idle = 4'hF;
    w = 0;
    while (!exhausted && w < 5) begin
      tick();
      w++;
    end
    check("exhausted_set", {busy, exhausted}, 64'b11);
    tick();
    check("exhausted_level", 64'(exhausted), 64'd1);

    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    check("abort_from_done", {core_stop, busy, exhausted}, 64'b100);

    // Simultaneous start/abort in IDLE: abort wins, nothing dispatched.
    job_start = 1'b1; job_abort = 1'b1;
    tick();
    job_start = 1'b0; job_abort = 1'b0;
    check("start_abort_idle", 64'(busy), 64'd0);

    // Claim arbitration and host responses, cores held busy so nothing dispatches.
    core_idle = 4'h0;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    check("claim_job_running", 64'(busy), 64'd1);
    for (int k = 0; k < 6; k++) begin
      core_found = core_found | tbl[k].found_set;
      expect_claim(tbl[k].exp_core);
      wait_claim();
      core_found = core_found & ~(N'(1) << tbl[k].exp_core);
      tick();
      check("claim_hold", 64'(sol_claim), 64'd1);
      sol_response = tbl[k].resp;
      tick();
      sol_response = 2'b00;
      check("claim_release", {sol_claim, core_stop}, {63'd0, tbl[k].exp_stop});
    end
    tick();
    check("accept_done", {busy, exhausted, core_stop}, 64'b100);

    // Host stalls for 100 cycles, then accepts.
    job_abort = 1'b1; tick(); job_abort = 1'b0;
    job_start = 1'b1; tick(); job_start = 1'b0;
    core_found = 4'b0100;
    expect_claim(2);
    wait_claim();
    core_found = '0;
    stable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (sol_claim !== 1'b1 || sol_nonce !== nonce_of(2)) stable = 1'b0;
    end
    check("hold_100_stable", 64'(stable), 64'd1);
    sol_response = 2'b01;
    tick();
    sol_response = 2'b00;
    check("accept_stop", {core_stop, sol_claim}, 64'b10);
    tick();
    check("accept_in_done", {core_stop, busy, exhausted}, 64'b010);

    // Abort collides with an accept: abort wins, no DONE.
    job_abort = 1'b1; tick(); job_abort = 1'b0;
    job_start = 1'b1; tick(); job_start = 1'b0;
    core_found = 4'b0001;
    expect_claim(0);
    wait_claim();
    core_found = '0;
    job_abort = 1'b1; sol_response = 2'b01;
    tick();
    job_abort = 1'b0; sol_response = 2'b00;
    check("abort_accept_stop", {core_stop, sol_claim, busy}, 64'b100);
    tick();
    check("abort_accept_idle", {core_stop, busy, exhausted}, 64'd0);

`ifdef NONCE_SCHEDULER_STATS_EN
    s_core_idle = 4'hF;
    s_job_start = 1'b1;
    @(posedge clk); #1;
    s_job_start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    s_core_idle = 4'h0;
    @(posedge clk); #1;
    s_core_idle = 4'hF;
    repeat (2) begin @(posedge clk); #1; end
    s_core_idle = 4'h0;
    repeat (2) begin @(posedge clk); #1; end
    s_job_abort = 1'b1;
    @(posedge clk); #1;
    s_job_abort = 1'b0;
    @(posedge clk); #1;
    check("stats_six", 64'(s_chunks_done), 64'd6);
    s_job_start = 1'b1;
    @(posedge clk); #1;
    s_job_start = 1'b0;
    check("stats_cleared", 64'(s_chunks_done), 64'd0);
`endif

    check("go_queue_drained", 64'(go_q.size()), 64'd0);
    check("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
